// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] index;
    logic [31:0] offset;
  } addr_split_t;

  function automatic int off_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int words);
    return 30 - $clog2(lines) - $clog2(words);
  endfunction

  // Fields come back right-justified in 32 bits; callers slice to their widths.
  function automatic addr_split_t split_addr(input logic [31:0] a, input int ob, input int ib);
    addr_split_t s;
    s.offset = (a >> 2) & ((32'd1 << ob) - 32'd1);
    s.index  = (a >> (2 + ob)) & ((32'd1 << ib) - 32'd1);
    s.tag    = a >> (2 + ob + ib);
    return s;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: combinational read port, one synchronous write port.
module dcache_line_store import dcache_pkg::*; #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = idx_bits(LINES),
  parameter int OFF_W          = off_bits(WORDS_PER_LINE),
  parameter int TAG_W          = tag_bits(LINES, WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [OFF_W-1:0] rd_offset,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             word_we,
  input  logic             tag_we
);

  logic [LINES-1:0]                     valid;
  logic [TAG_W-1:0]                     tags [LINES];
  logic [WORDS_PER_LINE-1:0][31:0]      data [LINES];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index][rd_offset];

  always_ff @(posedge clk) begin
    if (rst)         valid <= '0;
    else if (tag_we) valid[wr_index] <= 1'b1;
  end

  // Tag and data contents are don't-care while the line is invalid.
  always_ff @(posedge clk) begin
    if (word_we) data[wr_index][wr_offset] <= wr_data;
    if (tag_we)  tags[wr_index] <= wr_tag;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through D-cache controller with line fill over a ready handshake.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_W = off_bits(WORDS_PER_LINE);
  localparam int IDX_W = idx_bits(LINES);
  localparam int TAG_W = tag_bits(LINES, WORDS_PER_LINE);
  localparam logic [31:0]      LINE_MASK = ~((32'(WORDS_PER_LINE) << 2) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t           state;
  logic [OFF_W-1:0] beat;
  logic [31:0]      line_base, req_addr, req_data;

  logic [31:0]      act_addr;
  addr_split_t      as;
  logic             rd_valid, hit, fill_beat, word_we, tag_we;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data, wr_data;
  logic             unused_bits;

  // The single lookup port follows whichever address the current state owns.
  always_comb begin
    act_addr = cpu_addr;
    unique case (state)
      FILL:    act_addr = line_base | 32'({beat, 2'b00});
      WRITE:   act_addr = req_addr;
      default: ;
    endcase
  end

  assign as          = split_addr(act_addr, OFF_W, IDX_W);
  assign hit         = rd_valid && (32'(rd_tag) == as.tag);
  assign unused_bits = ^{as.index[31:IDX_W], as.offset[31:OFF_W], act_addr[1:0]};

  assign fill_beat = (state == FILL) && mem_ready;
  assign word_we   = !rst && (fill_beat || ((state == WRITE) && mem_ready && hit));
  assign tag_we    = !rst && fill_beat && (beat == LAST_BEAT);
  assign wr_data   = (state == FILL) ? mem_rdata : req_data;

  dcache_line_store #(.LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (as.index[IDX_W-1:0]),
    .rd_offset(as.offset[OFF_W-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_index (as.index[IDX_W-1:0]),
    .wr_offset(as.offset[OFF_W-1:0]),
    .wr_data  (wr_data),
    .wr_tag   (as.tag[TAG_W-1:0]),
    .word_we  (word_we),
    .tag_we   (tag_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      line_base <= '0;
      req_addr  <= '0;
      req_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_read && !hit) begin
            line_base <= cpu_addr & LINE_MASK;
            beat      <= '0;
            state     <= FILL;
          end else if (cpu_write) begin
            req_addr <= {cpu_addr[31:2], 2'b00};
            req_data <= cpu_wdata;
            state    <= WRITE;
          end
        end
        FILL: begin
          if (mem_ready) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) state <= IDLE;
          end
        end
        WRITE: if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall_mem = 1'b1;
    unique case (state)
      IDLE:    stall_mem = (cpu_read && !hit) || cpu_write;
      WRITE:   stall_mem = !mem_ready;
      default: stall_mem = 1'b1;
    endcase
  end

  assign cpu_rdata = rd_data;
  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = mem_req ? act_addr : '0;
  assign mem_wdata = req_data;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && cpu_read) begin
      if (hit && hit_count != '1)        hit_count  <= hit_count + 32'd1;
      else if (!hit && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
